// File: rtl/stim_counter_pkg.sv
// Shared encodings and helpers for the stimulus counter.
package stim_counter_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned GRAY_W = 16;

    localparam logic [MODE_W-1:0] MODE_UP   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_DOWN = 2'b01;
    localparam logic [MODE_W-1:0] MODE_SAT  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_GRAY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Reflected binary code of a value (callers zero-extend and truncate).
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/stim_tick_gen.sv
// Interval timer: after load, emits a one-cycle tick every 'period' enabled cycles.
module stim_tick_gen #(
    parameter int unsigned CNTW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            en,
    input  logic [CNTW-1:0] period,
    output logic            tick_c
);

    logic [CNTW-1:0] period_q;
    logic [CNTW-1:0] cnt_q;

    // Tick when the countdown reaches one; period is never zero here.
    assign tick_c = en && (cnt_q == CNTW'(1));

    // Countdown register, reloaded on load and after every tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            period_q <= period;
            cnt_q    <= period;
        end else if (en) begin
            cnt_q <= tick_c ? period_q : cnt_q - CNTW'(1);
        end
    end

endmodule

// File: rtl/stim_counter.sv
// Programmable burst pattern generator: up/down/saturating/gray counting at a fixed interval.
module stim_counter
    import stim_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] init_val,
    input  logic [CNTW-1:0]  n_steps,
    input  logic [CNTW-1:0]  interval,
    output logic [WIDTH-1:0] pat_out,
    output logic             step_stb,
    output logic             wrap_stb,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] init_q;
    logic [CNTW-1:0]  steps_q;
    logic [CNTW-1:0]  ival_q;
    logic [WIDTH-1:0] value_q, value_d;
    logic [CNTW-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0] next_val_c;
    logic [WIDTH-1:0] pat_d;
    logic             tick_c;
    logic             adv_c;
    logic             wrap_c;
    logic             wrap_d;
    logic             pat_en_c;

    stim_tick_gen #(.CNTW(CNTW)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == ST_LOAD),
        .en     (state_q == ST_RUN),
        .period (ival_q),
        .tick_c (tick_c)
    );

    // Next-state, advance arithmetic and next output values.
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        rem_d      = rem_q;
        adv_c      = 1'b0;
        wrap_c     = 1'b0;
        pat_en_c   = 1'b0;
        next_val_c = value_q + WIDTH'(1);

        case (mode_q)
            MODE_DOWN: begin
                next_val_c = value_q - WIDTH'(1);
                wrap_c     = (value_q == '0);
            end
            MODE_SAT: begin
                next_val_c = (value_q == '1) ? value_q : value_q + WIDTH'(1);
            end
            default: begin
                wrap_c = (value_q == '1);
            end
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                value_d  = init_q;
                rem_d    = steps_q;
                pat_en_c = 1'b1;
                state_d  = (steps_q != '0) ? ST_RUN : ST_FIN;
            end
            ST_RUN: begin
                if (tick_c) begin
                    adv_c    = 1'b1;
                    pat_en_c = 1'b1;
                    value_d  = next_val_c;
                    rem_d    = rem_q - CNTW'(1);
                    if (rem_q == CNTW'(1)) state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wrap_d = adv_c && wrap_c;
        pat_d  = (mode_q == MODE_GRAY) ? WIDTH'(bin2gray(GRAY_W'(value_d))) : value_d;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Burst configuration captured when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= '0;
            init_q  <= '0;
            steps_q <= '0;
            ival_q  <= '0;
        end else if (state_q == ST_IDLE && start) begin
            mode_q  <= mode;
            init_q  <= init_val;
            steps_q <= n_steps;
            ival_q  <= (interval == '0) ? CNTW'(1) : interval;
        end
    end

    // Working value, step counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= '0;
            rem_q    <= '0;
            pat_out  <= '0;
            step_stb <= 1'b0;
            wrap_stb <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            value_q  <= value_d;
            rem_q    <= rem_d;
            if (pat_en_c) pat_out <= pat_d;
            step_stb <= adv_c;
            wrap_stb <= wrap_d;
            busy     <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            done     <= (state_d == ST_FIN);
        end
    end

endmodule

// File: tb/tb_stim_counter.sv
// Bench for stim_counter: three widths driven in lockstep against an arithmetic model.
module tb_stim_counter;

    localparam int ND = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [1:0] mode     = 2'd0;
    logic [3:0] init_val = 4'd0;
    logic [3:0] n_steps  = 4'd0;
    logic [3:0] interval = 4'd0;

    logic [1:0]    pat2;
    logic [2:0]    pat3;
    logic [3:0]    pat4;
    logic [ND-1:0] step_a, wrap_a, busy_a, done_a;
    logic [31:0]   pat_a [ND];

    always_comb begin
        pat_a[0] = 32'(pat2);
        pat_a[1] = 32'(pat3);
        pat_a[2] = 32'(pat4);
    end

    stim_counter #(.WIDTH(2), .CNTW(4)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .init_val(init_val[1:0]),
        .n_steps(n_steps), .interval(interval), .pat_out(pat2), .step_stb(step_a[0]),
        .wrap_stb(wrap_a[0]), .busy(busy_a[0]), .done(done_a[0]));

    stim_counter #(.WIDTH(3), .CNTW(4)) u_w3 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .init_val(init_val[2:0]),
        .n_steps(n_steps), .interval(interval), .pat_out(pat3), .step_stb(step_a[1]),
        .wrap_stb(wrap_a[1]), .busy(busy_a[1]), .done(done_a[1]));

    stim_counter #(.WIDTH(4), .CNTW(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .init_val(init_val),
        .n_steps(n_steps), .interval(interval), .pat_out(pat4), .step_stb(step_a[2]),
        .wrap_stb(wrap_a[2]), .busy(busy_a[2]), .done(done_a[2]));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pat  [ND];
    int step_cnt [ND];
    int wrap_cnt [ND];

    typedef struct {
        int m, iv, ns, it;
        bit poke;
        int fin [ND];
        int wr  [ND];
    } vec_t;
    vec_t vecs[$];

    function automatic int wid(int d);
        return d + 2;
    endfunction

    // Model: one advance of a w-bit value under mode m.
    function automatic int adv(int w, int m, int v);
        int top = (1 << w) - 1;
        case (m)
            1:       return (v == 0) ? top : v - 1;
            2:       return (v == top) ? top : v + 1;
            default: return (v + 1) % (top + 1);
        endcase
    endfunction

    function automatic bit wraps_at(int w, int m, int v);
        int top = (1 << w) - 1;
        case (m)
            0, 3:    return v == top;
            1:       return v == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int shown(int m, int v);
        return (m == 3) ? (v ^ (v >> 1)) : v;
    endfunction

    task automatic chk(input string name, input int d, input int c,
                       input logic [31:0] act, input int expv);
        n_checks++;
        if (act !== 32'(expv)) begin
            n_fail++;
            $display("FAIL %s w%0d cyc=%0d: got %0d expected %0d", name, wid(d), c, act, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk({tag, "_pat"},  d, 0, pat_a[d],  0);
            chk({tag, "_step"}, d, 0, 32'(step_a[d]), 0);
            chk({tag, "_wrap"}, d, 0, 32'(wrap_a[d]), 0);
            chk({tag, "_busy"}, d, 0, 32'(busy_a[d]), 0);
            chk({tag, "_done"}, d, 0, 32'(done_a[d]), 0);
        end
    endtask

    // Run one burst from IDLE, checking every cycle; entered and left just after a negedge.
    task automatic run_burst(input int m, input int iv, input int ns, input int it, input bit poke);
        int per, last;
        int mv [ND];
        per  = (it == 0) ? 1 : it;
        last = (ns == 0) ? 1 : 1 + ns * per;
        mode = 2'(m); init_val = 4'(iv); n_steps = 4'(ns); interval = 4'(it);
        start = 1'b1;
        for (int d = 0; d < ND; d++) begin
            step_cnt[d] = 0; wrap_cnt[d] = 0; mv[d] = 0;
        end
        for (int c = 0; c <= last + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                bit st, wr;
                int w;
                w  = wid(d);
                st = 1'b0;
                wr = 1'b0;
                if (c == 1) begin
                    mv[d] = iv % (1 << w);
                    exp_pat[d] = shown(m, mv[d]);
                end else if (c > 1 && (c - 1) % per == 0 && (c - 1) / per <= ns) begin
                    st = 1'b1;
                    wr = wraps_at(w, m, mv[d]);
                    mv[d] = adv(w, m, mv[d]);
                    exp_pat[d] = shown(m, mv[d]);
                end
                chk("pat_out",  d, c, pat_a[d], exp_pat[d]);
                chk("step_stb", d, c, 32'(step_a[d]), int'(st));
                chk("wrap_stb", d, c, 32'(wrap_a[d]), int'(wr));
                chk("busy",     d, c, 32'(busy_a[d]), int'(c < last));
                chk("done",     d, c, 32'(done_a[d]), int'(c == last));
                step_cnt[d] += int'(step_a[d]);
                wrap_cnt[d] += int'(wrap_a[d]);
            end
            start = 1'b0;
            if (poke && c == 1) begin
                start = 1'b1;
                mode = 2'($urandom); init_val = 4'($urandom);
                n_steps = 4'($urandom); interval = 4'($urandom);
            end
            if (poke && c == last) start = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic add_vec(input int m, input int iv, input int ns, input int it, input bit poke,
                           input int f2, input int f3, input int f4,
                           input int w2, input int w3, input int w4);
        vec_t v;
        v.m = m; v.iv = iv; v.ns = ns; v.it = it; v.poke = poke;
        v.fin[0] = f2; v.fin[1] = f3; v.fin[2] = f4;
        v.wr[0]  = w2; v.wr[1]  = w3; v.wr[2]  = w4;
        vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //       m  iv ns it poke  final pat_out w2/w3/w4   wraps w2/w3/w4
        add_vec(0,  0, 8, 10, 1'b1,   0, 0,  8,              2, 1, 0);
        add_vec(1,  1, 3,  1, 1'b0,   2, 6, 14,              1, 1, 1);
        add_vec(2,  6, 4,  2, 1'b0,   3, 7, 10,              0, 0, 0);
        add_vec(3,  0, 7,  1, 1'b1,   2, 4,  4,              1, 0, 0);
        add_vec(0,  5, 0,  3, 1'b1,   1, 5,  5,              0, 0, 0);
        add_vec(0, 14, 3,  0, 1'b0,   1, 1,  1,              1, 1, 1);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        for (int d = 0; d < ND; d++) exp_pat[d] = 0;

        foreach (vecs[i]) begin
            run_burst(vecs[i].m, vecs[i].iv, vecs[i].ns, vecs[i].it, vecs[i].poke);
            for (int d = 0; d < ND; d++) begin
                chk("final_pat",  d, i, pat_a[d], vecs[i].fin[d]);
                chk("step_count", d, i, 32'(step_cnt[d]), vecs[i].ns);
                chk("wrap_count", d, i, 32'(wrap_cnt[d]), vecs[i].wr[d]);
            end
        end

        // Reset in the middle of a run, then a fresh full burst.
        mode = 2'd0; init_val = 4'd3; n_steps = 4'd9; interval = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        chk_all_zero("midrst_hold");
        rst_n = 1'b1;
        for (int d = 0; d < ND; d++) exp_pat[d] = 0;
        run_burst(0, 3, 9, 2, 1'b0);
        for (int d = 0; d < ND; d++) chk("post_rst_steps", d, 0, 32'(step_cnt[d]), 9);

        // Randomised bursts checked cycle by cycle against the model.
        for (int r = 0; r < 25; r++) begin
            run_burst(int'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
                      int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                      1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stim_counter.md
STIM_COUNTER -- requirements
Module: stim_counter

Interface
REQ-001 Parameter WIDTH, default 2, pattern width in bits (1..16).
REQ-002 Parameter CNTW, default 4, width of the step-count and interval fields.
REQ-003 Port clk  input  1  sole clock, rising-edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  one-cycle request to begin a burst; ignored unless IDLE.
REQ-006 Port mode  input  2  latched at start: 00 up-wrap, 01 down-wrap, 10 up-saturate, 11 gray-up.
REQ-007 Port init_val  input  WIDTH  binary starting value, latched at start.
REQ-008 Port n_steps  input  CNTW  number of advances per burst, latched at start; 0 means no advance.
REQ-009 Port interval  input  CNTW  clock cycles between advances, latched at start; 0 treated as 1.
REQ-010 Port pat_out  output  WIDTH  current pattern: binary value, or its gray code in mode 11.
REQ-011 Port step_stb  output  1  one-cycle pulse in the cycle pat_out takes a new value.
REQ-012 Port wrap_stb  output  1  one-cycle pulse coincident with step_stb when the binary value wraps (all-ones to zero up, zero to all-ones down).
REQ-013 Port busy  output  1  high in LOAD and RUN.
REQ-014 Port done  output  1  one-cycle pulse when a burst completes.

Function
REQ-015 FSM states IDLE, LOAD, RUN, FIN; reset state IDLE.
REQ-016 IDLE -> LOAD on start; LOAD latches mode, init_val, n_steps and the clamped interval, and loads the binary value with init_val.
REQ-017 pat_out reflects init_val from the cycle after LOAD; no step_stb is issued for the load.
REQ-018 LOAD -> RUN when n_steps > 0, else LOAD -> FIN.
REQ-019 In RUN an interval timer counts clock cycles; the first advance occurs exactly interval cycles after LOAD, each later advance interval cycles after the previous one.
REQ-020 Advance rules: mode 00 is value+1 mod 2^WIDTH; mode 01 is value-1 mod 2^WIDTH; mode 10 is value+1, holding at all-ones; mode 11 is value+1 mod 2^WIDTH with pat_out = value XOR (value>>1).
REQ-021 step_stb pulses on every advance, including advances that hold at saturation in mode 10.
REQ-022 wrap_stb never pulses in mode 10.
REQ-023 A remaining-steps counter loaded with n_steps decrements on each advance; the advance that brings it to 0 moves RUN -> FIN in the same edge.
REQ-024 FIN asserts done for exactly one cycle, then goes to IDLE; pat_out holds its last value in IDLE until the next LOAD.
REQ-025 start in LOAD, RUN or FIN is ignored, with no restart and no queuing.
REQ-026 start in the same cycle done is high is ignored; a new burst is accepted from IDLE on the following cycle.
REQ-027 Input changes after LOAD have no effect on the running burst.
REQ-028 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-029 Asserting rst_n low at any time, including mid-burst, immediately forces IDLE, pat_out=0, step_stb=0, wrap_stb=0, busy=0, done=0, and clears all counters and latched fields.
REQ-030 After rst_n deasserts, the first start is honoured on the first rising edge at which it is sampled high.

Structure
REQ-031 A shared package holds the mode encodings (MODE_UP, MODE_DOWN, MODE_SAT, MODE_GRAY), the FSM state enumeration, and a binary-to-gray conversion function.
REQ-032 The interval timer is one sub-module, stim_tick_gen (CNTW-wide, load/enable in, one-cycle tick out); everything else lives in stim_counter.

Verification
REQ-033 WIDTH=2, mode 00, init 0, n_steps 8, interval 10 -> pat_out 1,2,3,0,1,2,3,0 at cycles 10,20,...,80 after LOAD; wrap_stb at the 4th and 8th steps; done once; busy low afterwards.
REQ-034 WIDTH=4, mode 01, init 1, n_steps 3, interval 1 -> pat_out 0,F,E on consecutive cycles; wrap_stb on the 0->F step only.
REQ-035 WIDTH=3, mode 10, init 6, n_steps 4, interval 2 -> binary 7,7,7,7; four step_stb; no wrap_stb.
REQ-036 WIDTH=3, mode 11, init 0, n_steps 7, interval 1 -> pat_out 1,3,2,6,7,5,4.
REQ-037 n_steps 0 -> busy for LOAD only, done after 1 cycle, no step_stb; interval 0 -> advances every cycle.
REQ-038 Mid-burst start is ignored and the burst finishes unchanged; rst_n pulsed low mid-RUN clears all outputs to 0 and a fresh start runs a correct full burst.
